// File: rtl/cpu_dmem_if_if.sv
// Memory-stage request/response and pipelined data-bus signals of cpu_dmem_if.
// master: the bus interface block; slave: the memory stage plus the data-bus slave.
interface cpu_dmem_if_if #(
  parameter int ADDR_W = 32
) ();
  logic              cpu_req_in;
  logic              cpu_we_in;
  logic [1:0]        cpu_size_in;
  logic              cpu_uns_in;
  logic [ADDR_W-1:0] cpu_addr_in;
  logic [31:0]       cpu_wdata_in;
  logic              cpu_stall_out;
  logic              cpu_done_out;
  logic              cpu_err_out;
  logic [31:0]       cpu_rdata_out;
  logic              data_cyc_out;
  logic              data_stb_out;
  logic              data_we_out;
  logic [3:0]        data_be_out;
  logic [ADDR_W-1:0] data_addr_out;
  logic [31:0]       data_data_out;
  logic [31:0]       data_data_in;
  logic              data_ack_in;
  logic              data_stall_in;

  modport master (
    input  cpu_req_in, cpu_we_in, cpu_size_in, cpu_uns_in, cpu_addr_in, cpu_wdata_in,
    output cpu_stall_out, cpu_done_out, cpu_err_out, cpu_rdata_out,
    output data_cyc_out, data_stb_out, data_we_out, data_be_out, data_addr_out, data_data_out,
    input  data_data_in, data_ack_in, data_stall_in
  );

  modport slave (
    output cpu_req_in, cpu_we_in, cpu_size_in, cpu_uns_in, cpu_addr_in, cpu_wdata_in,
    input  cpu_stall_out, cpu_done_out, cpu_err_out, cpu_rdata_out,
    input  data_cyc_out, data_stb_out, data_we_out, data_be_out, data_addr_out, data_data_out,
    output data_data_in, data_ack_in, data_stall_in
  );
endinterface

// File: rtl/cpu_dmem_if.sv
// Single-outstanding load/store bridge from the CPU memory stage to a pipelined Wishbone-style bus:
// lane placement, load extension, misalignment and ack-timeout errors, pipeline stall.
module cpu_dmem_if #(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input logic           sys_clk,
  input logic           sys_rst,
  cpu_dmem_if_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [8:0] TO_LIM = 9'(TIMEOUT);

  state_t            state;
  logic [7:0]        cnt;
  logic [1:0]        size_q;
  logic [1:0]        off_q;
  logic              uns_q;
  logic              done_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic              cyc_q;
  logic              stb_q;
  logic              we_q;
  logic [3:0]        be_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic [1:0]        off;
  logic              misaligned;
  logic [3:0]        lane_be;
  logic [31:0]       lane_data;

  assign off = bus.cpu_addr_in[1:0];

  always_comb begin
    lane_be    = 4'b0000;
    lane_data  = bus.cpu_wdata_in;
    misaligned = 1'b0;
    case (bus.cpu_size_in)
      2'b00: begin
        lane_be   = 4'b0001 << off;
        lane_data = {4{bus.cpu_wdata_in[7:0]}};
      end
      2'b01: begin
        lane_be    = 4'b0011 << {off[1], 1'b0};
        lane_data  = {2{bus.cpu_wdata_in[15:0]}};
        misaligned = off[0];
      end
      2'b10: begin
        lane_be    = 4'b1111;
        misaligned = |off;
      end
      default: misaligned = 1'b1;
    endcase
  end

  function automatic logic [31:0] load_ext(input logic [31:0] d, input logic [1:0] o,
                                           input logic [1:0] sz, input logic uns);
    logic [31:0] s;
    s = d >> {o, 3'b000};
    case (sz)
      2'b00:   load_ext = uns ? {24'h0, s[7:0]}  : {{24{s[7]}}, s[7:0]};
      2'b01:   load_ext = uns ? {16'h0, s[15:0]} : {{16{s[15]}}, s[15:0]};
      default: load_ext = s;
    endcase
  endfunction

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state   <= IDLE;
      cnt     <= 8'd0;
      size_q  <= 2'b00;
      off_q   <= 2'b00;
      uns_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= 4'b0000;
      addr_q  <= '0;
      wdata_q <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req_in) begin
            size_q <= bus.cpu_size_in;
            off_q  <= off;
            uns_q  <= bus.cpu_uns_in;
            if (misaligned) begin
              state   <= DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
              rdata_q <= 32'h0;
            end else begin
              state   <= REQ;
              cyc_q   <= 1'b1;
              stb_q   <= 1'b1;
              we_q    <= bus.cpu_we_in;
              be_q    <= lane_be;
              addr_q  <= {bus.cpu_addr_in[ADDR_W-1:2], 2'b00};
              wdata_q <= lane_data;
            end
          end
        end
        REQ: begin
          if (!bus.data_stall_in) begin
            stb_q <= 1'b0;
            cnt   <= 8'd0;
            if (bus.data_ack_in) begin
              state   <= DONE;
              cyc_q   <= 1'b0;
              done_q  <= 1'b1;
              err_q   <= 1'b0;
              rdata_q <= we_q ? 32'h0 : load_ext(bus.data_data_in, off_q, size_q, uns_q);
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          // An ack in the final counted cycle still completes the access cleanly.
          if (bus.data_ack_in) begin
            state   <= DONE;
            cyc_q   <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b0;
            rdata_q <= we_q ? 32'h0 : load_ext(bus.data_data_in, off_q, size_q, uns_q);
          end else if (({1'b0, cnt} + 9'd1) == TO_LIM) begin
            state   <= DONE;
            cyc_q   <= 1'b0;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            rdata_q <= 32'h0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        DONE: begin
          state   <= IDLE;
          cnt     <= 8'd0;
          done_q  <= 1'b0;
          err_q   <= 1'b0;
          rdata_q <= 32'h0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stall is forced low while reset is held, even with a request pending.
  assign bus.cpu_stall_out = sys_rst &&
                             (((state == IDLE) && bus.cpu_req_in) || (state == REQ) || (state == WAIT));
  assign bus.cpu_done_out  = done_q;
  assign bus.cpu_err_out   = err_q;
  assign bus.cpu_rdata_out = rdata_q;
  assign bus.data_cyc_out  = cyc_q;
  assign bus.data_stb_out  = stb_q;
  assign bus.data_we_out   = we_q;
  assign bus.data_be_out   = be_q;
  assign bus.data_addr_out = addr_q;
  assign bus.data_data_out = wdata_q;

endmodule

// File: tb/tb_cpu_dmem_if.sv
// Bench for cpu_dmem_if: directed scenarios plus random accesses checked against an arithmetic lane/extension model.
module tb_cpu_dmem_if;
  localparam int TO = 4;

  logic sys_clk = 1'b0;
  logic sys_rst = 1'b0;
  int   n_cmp   = 0;
  int   n_fail  = 0;

  cpu_dmem_if_if #(.ADDR_W(32)) bus ();
  cpu_dmem_if #(.TIMEOUT(TO), .ADDR_W(32)) dut (.sys_clk(sys_clk), .sys_rst(sys_rst), .bus(bus));

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic        done_seen;
    int          done_cyc;
    int          stall_cnt;
    int          cyc_cnt;
    int          stb_cnt;
    int          wait_cnt;
    logic        err;
    logic [31:0] rdata;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] data;
    logic        unstable;
    logic        done_after;
    logic        stall_after;
  } obs_t;

  function automatic logic is_mis(input logic [1:0] size, input logic [31:0] addr);
    int o = int'(addr % 4);
    return (size == 2'd3) || (size == 2'd1 && (o % 2) != 0) || (size == 2'd2 && o != 0);
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input logic [31:0] addr);
    int o = int'(addr % 4);
    if (size == 2'd0) return 4'(1 << o);
    if (size == 2'd1) return 4'(3 << (o / 2 * 2));
    return 4'hF;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] w);
    if (size == 2'd0) return (w % 256) * 32'h0101_0101;
    if (size == 2'd1) return (w % 65536) * 32'h0001_0001;
    return w;
  endfunction

  function automatic logic [31:0] m_rdata(input logic [1:0] size, input logic uns,
                                          input logic [31:0] addr, input logic [31:0] d);
    int          bits = (size == 2'd0) ? 8 : (size == 2'd1) ? 16 : 32;
    logic [31:0] v    = d / (32'h1 << (8 * int'(addr % 4)));
    logic [31:0] mask;
    if (bits == 32) return v;
    mask = (32'h1 << bits) - 32'h1;
    v = v & mask;
    if (!uns && v[bits-1]) v = v | ~mask;
    return v;
  endfunction

  // Drives one access, plays the bus slave (stalls n_stall strobe cycles, acks in strobe cycle when
  // ack_lat==0 or in WAIT cycle ack_lat), and records what the DUT did, cycle 0 being the request cycle.
  task automatic run_access(input logic we, input logic [1:0] size, input logic uns,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input int n_stall, input int ack_lat, input logic [31:0] sdata,
                            output obs_t o);
    int stb_seen = 0;
    int wait_seen = 0;
    o = '{default: 0};
    @(negedge sys_clk);
    bus.cpu_req_in = 1'b1;  bus.cpu_we_in = we;    bus.cpu_size_in = size;
    bus.cpu_uns_in = uns;   bus.cpu_addr_in = addr; bus.cpu_wdata_in = wdata;
    bus.data_stall_in = 1'b0; bus.data_ack_in = 1'b0;
    for (int c = 0; c < 300 && !o.done_seen; c++) begin
      if (c > 0) begin
        @(negedge sys_clk);
        bus.data_stall_in = 1'b0;
        bus.data_ack_in   = 1'b0;
        bus.data_data_in  = $urandom;
        if (bus.data_cyc_out && bus.data_stb_out) begin
          if (stb_seen < n_stall) bus.data_stall_in = 1'b1;
          else if (ack_lat == 0) begin bus.data_ack_in = 1'b1; bus.data_data_in = sdata; end
          stb_seen++;
        end else if (bus.data_cyc_out) begin
          wait_seen++;
          if (wait_seen == ack_lat) begin bus.data_ack_in = 1'b1; bus.data_data_in = sdata; end
        end else begin
          bus.data_ack_in = 1'($urandom_range(0, 1));
        end
      end
      #1;
      if (bus.cpu_stall_out) o.stall_cnt++;
      if (bus.data_stb_out) o.stb_cnt++;
      if (bus.data_cyc_out && !bus.data_stb_out) o.wait_cnt++;
      if (bus.data_cyc_out) begin
        o.cyc_cnt++;
        if (o.cyc_cnt == 1) begin
          o.we = bus.data_we_out; o.be = bus.data_be_out;
          o.addr = bus.data_addr_out; o.data = bus.data_data_out;
        end else if ({o.we, o.be, o.addr, o.data} !==
                     {bus.data_we_out, bus.data_be_out, bus.data_addr_out, bus.data_data_out}) begin
          o.unstable = 1'b1;
        end
      end
      if (bus.cpu_done_out) begin
        o.done_seen = 1'b1; o.done_cyc = c; o.err = bus.cpu_err_out; o.rdata = bus.cpu_rdata_out;
      end
    end
    @(negedge sys_clk);
    bus.cpu_req_in = 1'b0; bus.data_ack_in = 1'b0; bus.data_stall_in = 1'b0;
    #1;
    o.done_after  = bus.cpu_done_out;
    o.stall_after = bus.cpu_stall_out;
  endtask

  task automatic test_reset();
    bus.cpu_req_in = 1'b1; bus.cpu_we_in = 1'b0; bus.cpu_size_in = 2'd2; bus.cpu_uns_in = 1'b0;
    bus.cpu_addr_in = 32'h0; bus.cpu_wdata_in = 32'h0; bus.data_data_in = 32'h0;
    bus.data_ack_in = 1'b0; bus.data_stall_in = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    n_cmp++;
    if ({bus.cpu_stall_out, bus.cpu_done_out, bus.cpu_err_out, bus.cpu_rdata_out, bus.data_cyc_out,
         bus.data_stb_out, bus.data_we_out, bus.data_be_out, bus.data_addr_out, bus.data_data_out} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: stall=%b done=%b cyc=%b stb=%b be=%h addr=%h data=%h rdata=%h, all must be 0",
               bus.cpu_stall_out, bus.cpu_done_out, bus.data_cyc_out, bus.data_stb_out,
               bus.data_be_out, bus.data_addr_out, bus.data_data_out, bus.cpu_rdata_out);
    end
    @(negedge sys_clk);
    bus.cpu_req_in = 1'b0;
    sys_rst = 1'b1;
  endtask

  task automatic test_store_word();
    obs_t o;
    run_access(1'b1, 2'd2, 1'b0, 32'h104, 32'hDEADBEEF, 0, 0, 32'h0, o);
    n_cmp++;
    if (o.done_cyc !== 2 || o.stall_cnt !== 2 || o.stb_cnt !== 1) begin
      n_fail++;
      $display("FAIL sw_timing: done_cyc=%0d stall=%0d stb=%0d, want 2/2/1", o.done_cyc, o.stall_cnt, o.stb_cnt);
    end
    n_cmp++;
    if ({o.we, o.be, o.addr, o.data} !== {1'b1, 4'hF, 32'h104, 32'hDEADBEEF}) begin
      n_fail++;
      $display("FAIL sw_bus: we=%b be=%h addr=%h data=%h, want 1/f/00000104/deadbeef", o.we, o.be, o.addr, o.data);
    end
    n_cmp++;
    if ({o.err, o.rdata, o.done_after, o.stall_after} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL sw_resp: err=%b rdata=%h done_after=%b stall_after=%b, want 0/0/0/0",
               o.err, o.rdata, o.done_after, o.stall_after);
    end
  endtask

  task automatic test_load_byte();
    obs_t o;
    run_access(1'b0, 2'd0, 1'b0, 32'h203, 32'h0, 0, 3, 32'h80FFFFFF, o);
    n_cmp++;
    if ({o.we, o.be, o.addr} !== {1'b0, 4'b1000, 32'h200} || o.unstable !== 1'b0) begin
      n_fail++;
      $display("FAIL lb_bus: we=%b be=%b addr=%h unstable=%b, want 0/1000/00000200/0", o.we, o.be, o.addr, o.unstable);
    end
    n_cmp++;
    if (o.err !== 1'b0 || o.rdata !== 32'hFFFFFF80) begin
      n_fail++;
      $display("FAIL lb_resp: err=%b rdata=%h, want 0/ffffff80", o.err, o.rdata);
    end
    n_cmp++;
    if (o.done_cyc !== 5 || o.stall_cnt !== 5 || o.wait_cnt !== 3) begin
      n_fail++;
      $display("FAIL lb_timing: done_cyc=%0d stall=%0d wait=%0d, want 5/5/3", o.done_cyc, o.stall_cnt, o.wait_cnt);
    end
  endtask

  task automatic test_load_half_stalled();
    obs_t o;
    run_access(1'b0, 2'd1, 1'b1, 32'h202, 32'h0, 2, 0, 32'h80011234, o);
    n_cmp++;
    if (o.stb_cnt !== 3 || o.unstable !== 1'b0 || o.be !== 4'b1100 || o.addr !== 32'h200) begin
      n_fail++;
      $display("FAIL lhu_stall: stb=%0d unstable=%b be=%b addr=%h, want 3/0/1100/00000200",
               o.stb_cnt, o.unstable, o.be, o.addr);
    end
    n_cmp++;
    if (o.rdata !== 32'h00008001 || o.err !== 1'b0 || o.done_cyc !== 4) begin
      n_fail++;
      $display("FAIL lhu_resp: rdata=%h err=%b done_cyc=%0d, want 00008001/0/4", o.rdata, o.err, o.done_cyc);
    end
  endtask

  task automatic test_misaligned();
    obs_t o;
    logic [1:0]  sz [3] = '{2'd2, 2'd1, 2'd3};
    logic [31:0] ad [3] = '{32'h101, 32'h33, 32'h40};
    for (int i = 0; i < 3; i++) begin
      run_access(1'b0, sz[i], 1'b0, ad[i], 32'h0, 0, 0, 32'h12345678, o);
      n_cmp++;
      if (o.cyc_cnt !== 0 || o.stb_cnt !== 0 || o.done_cyc !== 1 || o.err !== 1'b1 ||
          o.rdata !== 32'h0 || o.stall_cnt !== 1) begin
        n_fail++;
        $display("FAIL misaligned[%0d]: cyc=%0d stb=%0d done_cyc=%0d err=%b rdata=%h stall=%0d, want 0/0/1/1/0/1",
                 i, o.cyc_cnt, o.stb_cnt, o.done_cyc, o.err, o.rdata, o.stall_cnt);
      end
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    run_access(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 0, 255, 32'hAAAA5555, o);
    n_cmp++;
    if (o.wait_cnt !== TO || o.err !== 1'b1 || o.rdata !== 32'h0 || o.done_cyc !== TO + 2) begin
      n_fail++;
      $display("FAIL timeout: wait=%0d err=%b rdata=%h done_cyc=%0d, want %0d/1/0/%0d",
               o.wait_cnt, o.err, o.rdata, o.done_cyc, TO, TO + 2);
    end
    run_access(1'b0, 2'd2, 1'b0, 32'h304, 32'h0, 0, TO, 32'hAAAA5555, o);
    n_cmp++;
    if (o.wait_cnt !== TO || o.err !== 1'b0 || o.rdata !== 32'hAAAA5555) begin
      n_fail++;
      $display("FAIL ack_at_timeout: wait=%0d err=%b rdata=%h, want %0d/0/aaaa5555", o.wait_cnt, o.err, o.rdata, TO);
    end
  endtask

  task automatic test_reset_mid_wait();
    obs_t o;
    @(negedge sys_clk);
    bus.cpu_req_in = 1'b1; bus.cpu_we_in = 1'b0; bus.cpu_size_in = 2'd2; bus.cpu_addr_in = 32'h100;
    bus.data_ack_in = 1'b0; bus.data_stall_in = 1'b0;
    repeat (3) @(negedge sys_clk);
    #2;
    n_cmp++;
    if (!(bus.data_cyc_out && !bus.data_stb_out)) begin
      n_fail++;
      $display("FAIL pre_reset_wait: cyc=%b stb=%b, want 1/0", bus.data_cyc_out, bus.data_stb_out);
    end
    sys_rst = 1'b0;
    #1;
    n_cmp++;
    if ({bus.data_cyc_out, bus.data_stb_out, bus.cpu_stall_out, bus.cpu_done_out} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_mid_wait: cyc=%b stb=%b stall=%b done=%b, want 0000",
               bus.data_cyc_out, bus.data_stb_out, bus.cpu_stall_out, bus.cpu_done_out);
    end
    @(negedge sys_clk);
    bus.cpu_req_in = 1'b0;
    sys_rst = 1'b1;
    run_access(1'b1, 2'd0, 1'b0, 32'h1, 32'h0000_005A, 0, 0, 32'h0, o);
    n_cmp++;
    if ({o.be, o.data, o.addr} !== {4'b0010, 32'h5A5A5A5A, 32'h0} || o.done_cyc !== 2 || o.err !== 1'b0) begin
      n_fail++;
      $display("FAIL sb_after_reset: be=%b data=%h addr=%h done_cyc=%0d err=%b, want 0010/5a5a5a5a/0/2/0",
               o.be, o.data, o.addr, o.done_cyc, o.err);
    end
  endtask

  task automatic test_random();
    obs_t o;
    for (int i = 0; i < 60; i++) begin
      int          r     = $urandom_range(0, 9);
      logic [1:0]  size  = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      logic        we    = 1'($urandom_range(0, 1));
      logic        uns   = 1'($urandom_range(0, 1));
      logic [31:0] addr  = $urandom;
      logic [31:0] wdata = $urandom;
      logic [31:0] sdata = $urandom;
      int          nst   = $urandom_range(0, 3);
      int          alat  = $urandom_range(0, TO + 2);
      int          w;
      int          exp_done;
      logic        exp_err;
      logic [31:0] exp_rd;
      if (is_mis(size, addr)) begin
        w = 0; exp_done = 1; exp_err = 1'b1; exp_rd = 32'h0;
      end else begin
        w        = (alat == 0) ? 0 : (alat <= TO) ? alat : TO;
        exp_done = nst + 2 + w;
        exp_err  = (alat > TO);
        exp_rd   = (we || exp_err) ? 32'h0 : m_rdata(size, uns, addr, sdata);
      end
      run_access(we, size, uns, addr, wdata, nst, alat, sdata, o);
      n_cmp++;
      if (o.done_seen !== 1'b1 || o.done_cyc !== exp_done || o.stall_cnt !== exp_done ||
          o.wait_cnt !== w || o.done_after !== 1'b0) begin
        n_fail++;
        $display("FAIL rnd_timing[%0d]: seen=%b done_cyc=%0d stall=%0d wait=%0d after=%b, want 1/%0d/%0d/%0d/0",
                 i, o.done_seen, o.done_cyc, o.stall_cnt, o.wait_cnt, o.done_after, exp_done, exp_done, w);
      end
      n_cmp++;
      if (o.err !== exp_err || o.rdata !== exp_rd) begin
        n_fail++;
        $display("FAIL rnd_resp[%0d]: size=%0d addr=%h err=%b rdata=%h, want %b/%h",
                 i, size, addr, o.err, o.rdata, exp_err, exp_rd);
      end
      if (!is_mis(size, addr)) begin
        n_cmp++;
        if ({o.we, o.be, o.addr, o.data} !== {we, m_be(size, addr), addr & 32'hFFFF_FFFC, m_wdata(size, wdata)} ||
            o.unstable !== 1'b0 || o.stb_cnt !== nst + 1) begin
          n_fail++;
          $display("FAIL rnd_bus[%0d]: we=%b be=%b addr=%h data=%h unstable=%b stb=%0d, want %b/%b/%h/%h/0/%0d",
                   i, o.we, o.be, o.addr, o.data, o.unstable, o.stb_cnt, we, m_be(size, addr),
                   addr & 32'hFFFF_FFFC, m_wdata(size, wdata), nst + 1);
        end
      end else begin
        n_cmp++;
        if (o.cyc_cnt !== 0) begin
          n_fail++;
          $display("FAIL rnd_nobus[%0d]: cyc cycles=%0d, want 0", i, o.cyc_cnt);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_load_half_stalled();
    test_misaligned();
    test_timeout();
    test_reset_mid_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_dmem_if.md
Name: cpu_dmem_if

Overview:
Data-memory bus interface between the CPU memory stage and the pipelined Wishbone-style data bus. It takes one load/store request at a time from the memory stage and drives a single bus cycle with byte-lane selects. It returns aligned, sign- or zero-extended load data and stalls the pipeline until the access completes. It also flags misaligned accesses and bus timeouts.

Parameters:
TIMEOUT, 255, cycles waited for data_ack_in after the strobe is accepted before the access ends with an error; legal range 1..255.
ADDR_W, 32, address width.

Ports:
sys_clk  in  1  clock
sys_rst  in  1  asynchronous, active-low reset
cpu_req_in  in  1  memory-stage access request, held until cpu_done_out
cpu_we_in  in  1  1 = store, 0 = load
cpu_size_in  in  2  00 byte, 01 half, 10 word, 11 illegal
cpu_uns_in  in  1  1 = zero-extend load, 0 = sign-extend
cpu_addr_in  in  ADDR_W  byte address
cpu_wdata_in  in  32  store data, LSB-justified
cpu_stall_out  out  1  freeze pipeline
cpu_done_out  out  1  one-cycle completion pulse
cpu_err_out  out  1  misaligned, illegal size or timeout; valid with done
cpu_rdata_out  out  32  extended load data; valid with done
data_cyc_out  out  1  bus cycle
data_stb_out  out  1  strobe
data_we_out  out  1  write enable
data_be_out  out  4  byte enables
data_addr_out  out  ADDR_W  word-aligned address
data_data_out  out  32  lane-placed write data
data_data_in  in  32  read data
data_ack_in  in  1  acknowledge
data_stall_in  in  1  slave cannot accept strobe

Behaviour:
- Reset (sys_rst=0, asynchronous): state IDLE, timeout counter 0. All outputs are 0: stall, done, err, rdata, cyc, stb, we, be, addr, data_out. Any bus cycle in progress is abandoned without waiting for ack.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: on cpu_req_in=1, capture addr, we, size, uns and lane-placed wdata/be.
  - Aligned request: next state REQ.
  - Misaligned request (half with addr[0]=1, word with addr[1:0]!=0, or size 11): next state DONE with err=1; no bus activity.
- REQ: cyc=1, stb=1.
  - data_stall_in=1: hold in REQ with all bus outputs stable.
  - data_stall_in=0 and data_ack_in=1 in the same cycle: go to DONE.
  - data_stall_in=0, no ack: go to WAIT.
- WAIT: cyc=1, stb=0, counter increments each cycle.
  - data_ack_in=1: go to DONE, err=0.
  - counter==TIMEOUT without ack: go to DONE, err=1, rdata=0.
  - An ack and the timeout in the same cycle: the ack wins.
- DONE: cyc=0, stb=0, done=1 for exactly one cycle; err and rdata valid; counter cleared; next state IDLE. A new request is taken in the following IDLE cycle, so the minimum spacing between accesses is 3 cycles.
- cpu_stall_out = (IDLE & cpu_req_in) | REQ | WAIT. It is combinational in IDLE and 0 in DONE.
- Byte lanes (little-endian), with off = addr[1:0]:
  - byte: be = 4'b0001 << off; write data is byte 0 replicated on all lanes.
  - half: be = 4'b0011 << {off[1],1'b0}; write data is halfword 0 replicated on both halves.
  - word: be = 4'b1111.
  - data_addr_out = {addr[ADDR_W-1:2],2'b00}.
- Load data: data_data_in is registered on ack, shifted right by 8*off, truncated to the access size, then extended per cpu_uns_in. Store completion returns rdata=0.
- data_we_out, data_be_out, data_addr_out and data_data_out are registered and stable from REQ entry until DONE. They hold their last values in IDLE; only cyc and stb qualify them.
- An ack arriving in IDLE or DONE (spurious) is ignored.

Test Plan:
- SW addr 0x104, wdata 0xDEADBEEF, no slave stall, ack in the strobe cycle -> one stb cycle with be=1111, addr=0x104, data=0xDEADBEEF; done 2 cycles after req; stall high for 2 cycles.
- LB addr 0x203, uns=0, slave returns 0x80FFFFFF after 3 wait cycles -> be=1000, addr=0x200, rdata=0xFFFFFF80, err=0; stall high until the done cycle.
- LHU addr 0x202, slave stalls 2 cycles then returns 0x8001xxxx -> stb held 3 cycles with stable outputs; rdata=0x00008001.
- LW addr 0x101 -> no cyc or stb asserted; done and err=1 the next cycle.
- Load with TIMEOUT=4 and no ack -> WAIT lasts 4 cycles; done and err=1; rdata=0; cyc drops.
- sys_rst driven low mid-WAIT -> cyc, stb, stall and done go to 0 immediately; after release, a new SB at addr 0x1 gives be=0010 and data=byte replicated.
